// File: rtl/debouncer_pkg.sv
// ============================================================================
// debouncer_pkg : shared count calculations for the multi-channel debouncer
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package debouncer_pkg;

  localparam int MAX_KEY_CNT = 32;

  // Glitch filter length in clock cycles, rounded up, never below one cycle.
  function automatic int calc_db_cnt(input int clk_freq_mhz, input int glitch_time_ns);
    longint prod;
    prod = longint'(clk_freq_mhz) * longint'(glitch_time_ns);
    calc_db_cnt = int'((prod + 64'sd999) / 64'sd1000);
    if (calc_db_cnt < 1) calc_db_cnt = 1;
  endfunction

  function automatic int calc_long_cnt(input int clk_freq_mhz, input int long_press_ms);
    longint prod;
    prod = longint'(clk_freq_mhz) * longint'(long_press_ms) * 64'sd1000;
    calc_long_cnt = int'(prod);
    if (calc_long_cnt < 1) calc_long_cnt = 1;
  endfunction

  function automatic int cnt_width(input int n);
    cnt_width = $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/debouncer_channel.sv
// ============================================================================
// debouncer_channel : one key - synchroniser, glitch counter, edge strobes
// Optional long-press detector built when DEBOUNCER_LONG_PRESS_EN is defined.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module debouncer_channel
  import debouncer_pkg::*;
#(
  parameter int DB_CNT     = 10,
  parameter int ACTIVE_LOW = 1
`ifdef DEBOUNCER_LONG_PRESS_EN
  ,
  parameter int LONG_CNT   = 10000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic state,
  output logic pressed_stb,
  output logic released_stb
`ifdef DEBOUNCER_LONG_PRESS_EN
  ,
  output logic long_press_stb
`endif
);

  localparam int            CW           = cnt_width(DB_CNT);
  localparam logic [CW-1:0] DB_LAST      = CW'(DB_CNT - 1);
  localparam logic          RELEASED_RAW = (ACTIVE_LOW != 0);

  logic          sync_meta;
  logic          sync_out;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= RELEASED_RAW;
      sync_out  <= RELEASED_RAW;
    end else begin
      sync_meta <= key_raw;
      sync_out  <= sync_meta;
    end
  end

  assign level = (ACTIVE_LOW != 0) ? ~sync_out : sync_out;

  // A toggle is held off for one cycle after a strobe so that a one-cycle
  // filter can never produce back-to-back strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      state        <= 1'b0;
      pressed_stb  <= 1'b0;
      released_stb <= 1'b0;
    end else begin
      pressed_stb  <= 1'b0;
      released_stb <= 1'b0;
      if (level == state) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        if (!(pressed_stb || released_stb)) begin
          state        <= level;
          cnt          <= '0;
          pressed_stb  <= level;
          released_stb <= ~level;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef DEBOUNCER_LONG_PRESS_EN
  localparam int            LW        = cnt_width(LONG_CNT);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CNT - 1);

  logic [LW-1:0] long_cnt;
  logic          long_done;

  // long_done blocks further pulses until the key is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_cnt       <= '0;
      long_done      <= 1'b0;
      long_press_stb <= 1'b0;
    end else begin
      long_press_stb <= 1'b0;
      if (!state) begin
        long_cnt  <= '0;
        long_done <= 1'b0;
      end else if (!long_done) begin
        if (long_cnt == LONG_LAST) begin
          long_press_stb <= 1'b1;
          long_done      <= 1'b1;
          long_cnt       <= '0;
        end else begin
          long_cnt <= long_cnt + 1'b1;
        end
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/multi_debouncer.sv
// ============================================================================
// multi_debouncer : KEY_CNT independent debounced key channels with strobes
// Optional long-press output built when DEBOUNCER_LONG_PRESS_EN is defined.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_debouncer
  import debouncer_pkg::*;
#(
  parameter int CLK_FREQ_MHZ   = 50,
  parameter int GLITCH_TIME_NS = 20000,
  parameter int KEY_CNT        = 4,
  parameter int ACTIVE_LOW     = 1
`ifdef DEBOUNCER_LONG_PRESS_EN
  ,
  parameter int LONG_PRESS_MS  = 1000
`endif
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [KEY_CNT-1:0] key_i,
  output logic [KEY_CNT-1:0] key_state_o,
  output logic [KEY_CNT-1:0] key_pressed_stb_o,
  output logic [KEY_CNT-1:0] key_released_stb_o
`ifdef DEBOUNCER_LONG_PRESS_EN
  ,
  output logic [KEY_CNT-1:0] long_press_stb_o
`endif
);

  localparam int DB_CNT   = calc_db_cnt(CLK_FREQ_MHZ, GLITCH_TIME_NS);
`ifdef DEBOUNCER_LONG_PRESS_EN
  localparam int LONG_CNT = calc_long_cnt(CLK_FREQ_MHZ, LONG_PRESS_MS);
`endif

  for (genvar k = 0; k < KEY_CNT; k++) begin : g_channel
    debouncer_channel #(
      .DB_CNT        (DB_CNT),
      .ACTIVE_LOW    (ACTIVE_LOW)
`ifdef DEBOUNCER_LONG_PRESS_EN
      ,
      .LONG_CNT      (LONG_CNT)
`endif
    ) u_channel (
      .clk           (clk_i),
      .rst_n         (rst_ni),
      .key_raw       (key_i[k]),
      .state         (key_state_o[k]),
      .pressed_stb   (key_pressed_stb_o[k]),
      .released_stb  (key_released_stb_o[k])
`ifdef DEBOUNCER_LONG_PRESS_EN
      ,
      .long_press_stb(long_press_stb_o[k])
`endif
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_debouncer.sv
// ============================================================================
// tb_multi_debouncer : scoreboard bench for multi_debouncer (DB_CNT = 10)
// Revision 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multi_debouncer;

  logic       clk;
  logic       rst_n;
  logic [3:0] key;
  logic [3:0] key_state;
  logic [3:0] pstb;
  logic [3:0] rstb;
  logic [3:0] lstb;

  multi_debouncer #(
    .CLK_FREQ_MHZ      (10),
    .GLITCH_TIME_NS    (1000),
    .KEY_CNT           (4),
    .ACTIVE_LOW        (1)
`ifdef DEBOUNCER_LONG_PRESS_EN
    ,
    .LONG_PRESS_MS     (1)
`endif
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .key_i             (key),
    .key_state_o       (key_state),
    .key_pressed_stb_o (pstb),
    .key_released_stb_o(rstb)
`ifdef DEBOUNCER_LONG_PRESS_EN
    ,
    .long_press_stb_o  (lstb)
`endif
  );

`ifndef DEBOUNCER_LONG_PRESS_EN
  assign lstb = 4'h0;
`endif

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] pr;
    logic [3:0] rl;
    logic [3:0] lg;
    logic [3:0] st;
  } ev_t;

  ev_t        q[$];
  ev_t        ev;
  logic [3:0] exp_state = 4'h0;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [3:0] pr, input logic [3:0] rl,
                      input logic [3:0] lg);
    ev_t e;
    exp_state = (exp_state | pr) & ~rl;
    e.cyc = c; e.pr = pr; e.rl = rl; e.lg = lg; e.st = exp_state;
    q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && (|{pstb, rstb, lstb})) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got p=%0h r=%0h l=%0h expected none (cycle %0d)",
                 pstb, rstb, lstb, cyc);
      end else begin
        ev = q.pop_front();
        check("strobe_cycle", cyc, ev.cyc);
        check("pressed_stb", int'(pstb), int'(ev.pr));
        check("released_stb", int'(rstb), int'(ev.rl));
        check("long_press_stb", int'(lstb), int'(ev.lg));
        check("key_state", int'(key_state), int'(ev.st));
      end
    end
  end

  int t;

  initial begin
    rst_n = 1'b0;
    key   = 4'hF;
    wait_cycles(3);
    check("reset_state", int'(key_state), 0);
    check("reset_pressed", int'(pstb), 0);
    check("reset_released", int'(rstb), 0);
    rst_n = 1'b1;
    wait_cycles(5);
    check("idle_state", int'(key_state), 0);

    // Single press on key 0
    key[0] = 1'b0; t = cyc;
    push(t + 12, 4'b0001, 4'b0000, 4'b0000);
    wait_cycles(20);

    // Key 1: repeated 9-cycle glitches never accepted
    for (int i = 0; i < 5; i++) begin
      key[1] = 1'b0; wait_cycles(9);
      key[1] = 1'b1; wait_cycles(9);
    end
    wait_cycles(15);
    check("glitch_state", int'(key_state[1]), 0);

    // Key 2 press then release after 50 cycles
    key[2] = 1'b0; t = cyc;
    push(t + 12, 4'b0100, 4'b0000, 4'b0000);
    wait_cycles(50);
    key[2] = 1'b1; t = cyc;
    push(t + 12, 4'b0000, 4'b0100, 4'b0000);
    wait_cycles(20);

    // Release key 0, then press keys 0 and 3 together
    key[0] = 1'b1; t = cyc;
    push(t + 12, 4'b0000, 4'b0001, 4'b0000);
    wait_cycles(20);
    key[0] = 1'b0; key[3] = 1'b0; t = cyc;
    push(t + 12, 4'b1001, 4'b0000, 4'b0000);
    wait_cycles(20);

    // Reset mid-count with key 1 pressed for 8 edges (count 6)
    key[1] = 1'b0;
    wait_cycles(8);
    rst_n = 1'b0;
    exp_state = 4'h0;
    wait_cycles(1);
    check("midreset_state", int'(key_state), 0);
    check("midreset_pressed", int'(pstb), 0);
    check("midreset_released", int'(rstb), 0);
    wait_cycles(2);
    rst_n = 1'b1; t = cyc;
    push(t + 12, 4'b1011, 4'b0000, 4'b0000);
    wait_cycles(20);

    key = 4'hF; t = cyc;
    push(t + 12, 4'b0000, 4'b1011, 4'b0000);
    wait_cycles(20);

`ifdef DEBOUNCER_LONG_PRESS_EN
    key[2] = 1'b0; t = cyc;
    push(t + 12, 4'b0100, 4'b0000, 4'b0000);
    push(t + 12 + 10000, 4'b0000, 4'b0000, 4'b0100);
    wait_cycles(25000);
    key[2] = 1'b1; t = cyc;
    push(t + 12, 4'b0000, 4'b0100, 4'b0000);
    wait_cycles(20);
`endif

    wait_cycles(30);
    check("pending_events", q.size(), 0);
    check("final_state", int'(key_state), int'(exp_state));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 SHALL have parameter CLK_FREQ_MHZ, default 50: clock frequency in MHz.
REQ-002 SHALL have parameter GLITCH_TIME_NS, default 20000: minimum stable time before a level is accepted.
REQ-003 SHALL have parameter KEY_CNT, default 4: number of independent key channels, legal range 1..32.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 = key pressed when key_i bit is 0.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock; all logic runs on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port key_i, input, KEY_CNT bits: raw asynchronous key levels, one bit per channel.
REQ-008 SHALL have port key_state_o, output, KEY_CNT bits: debounced level per channel, 1 = pressed, independent of ACTIVE_LOW.
REQ-009 SHALL have port key_pressed_stb_o, output, KEY_CNT bits: one-cycle pulse per channel on an accepted press.
REQ-010 SHALL have port key_released_stb_o, output, KEY_CNT bits: one-cycle pulse per channel on an accepted release.

Function
REQ-011 SHALL pass each key_i bit through a 2-flop synchroniser, then normalise polarity (invert when ACTIVE_LOW=1).
REQ-012 SHALL compute DB_CNT = ceil(CLK_FREQ_MHZ*GLITCH_TIME_NS/1000), clamped to a minimum of 1; counter width = $clog2(DB_CNT+1).
REQ-013 SHALL clear a channel's counter on any cycle where its normalised synced level equals key_state_o, and increment it otherwise.
REQ-014 SHALL, on the edge where the counter would reach DB_CNT, toggle key_state_o, clear the counter, and assert exactly one strobe for one cycle: pressed if the new state is 1, released if 0.
REQ-015 SHALL have a latency of DB_CNT+2 rising edges from the first edge sampling a clean new level on key_i to the edge asserting the strobe and the new key_state_o.
REQ-016 SHALL restart the count from 0 on any glitch shorter than DB_CNT cycles, leaving state and strobes unchanged.
REQ-017 SHALL keep channels fully independent; simultaneous events on several channels SHALL produce simultaneous strobes.
REQ-018 SHALL never assert pressed and released strobes for the same channel in the same cycle, and SHALL never assert two consecutive strobe cycles on one channel.
REQ-019 SHALL saturate no counter beyond DB_CNT, so no wrap-around is possible.

Reset
REQ-020 SHALL, while rst_ni=0, force key_state_o, both strobe outputs, and all counters to 0, and load the synchronisers with the released level (1 if ACTIVE_LOW=1).
REQ-021 SHALL discard an in-progress count when reset is asserted mid-operation; after release, a key held pressed SHALL produce a press strobe after the full latency.

Configuration
REQ-022 SHALL, when macro DEBOUNCER_LONG_PRESS_EN is defined, add parameter LONG_PRESS_MS (default 1000) and output long_press_stb_o (KEY_CNT bits).
REQ-023 SHALL, with the macro defined, pulse long_press_stb_o for one cycle, once per press, when key_state_o has been 1 for LONG_CNT = CLK_FREQ_MHZ*LONG_PRESS_MS*1000 cycles; the counter clears on release and on reset, and there is no auto-repeat.
REQ-024 SHALL, without the macro, omit both the port and the long-press counters entirely.

Structure
REQ-025 SHALL place the DB_CNT and LONG_CNT calculation functions and the counter-width helper in package debouncer_pkg.
REQ-026 SHALL implement one channel in sub-module debouncer_channel, instantiated KEY_CNT times through a generate loop.

Verification
REQ-027 Setup: CLK_FREQ_MHZ=10, GLITCH_TIME_NS=1000 (DB_CNT=10), ACTIVE_LOW=1, KEY_CNT=4.
- key_i[0] 1->0 held -> key_pressed_stb_o[0] high exactly one cycle at edge 12, key_state_o[0]=1 from that edge.
- key_i[1] low pulses of 9 cycles repeated 5 times -> no strobe, key_state_o[1] stays 0.
- Key 2 pressed then released after 50 cycles -> one press strobe, then one release strobe 12 edges after release.
- Keys 0 and 3 pressed on the same edge -> both press strobes in the same cycle.
- rst_ni pulsed low at count 6 with key held -> outputs 0 during reset; press strobe 12 edges after rst_ni rises.
- With DEBOUNCER_LONG_PRESS_EN and LONG_PRESS_MS=1, key held 25000 cycles -> exactly one long_press_stb_o pulse, 10000 cycles after the press strobe.
